// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if
//   Bundles the serial stream, configuration and status signals of
//   seq_detector_param.
//   master : drives stream/config (sequence_in, in_valid, cfg_load, pattern,
//            pattern_len, overlap) and observes the status outputs.
//   slave  : the detector; consumes stream/config and drives detector_out,
//            match_count, cfg_err and active.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               sequence_in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pattern_len;
    logic               overlap;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               active;

    modport master (
        output sequence_in, in_valid, cfg_load, pattern, pattern_len, overlap,
        input  detector_out, match_count, cfg_err, active
    );

    modport slave (
        input  sequence_in, in_valid, cfg_load, pattern, pattern_len, overlap,
        output detector_out, match_count, cfg_err, active
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Runtime-programmable serial sequence detector (pattern up to MAX_LEN
//   bits, MAX_LEN in 1..32) with registered match pulse, saturating match
//   counter and configuration-error flag.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_detector_param_if.slave (stream, config strobe, status)
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   UNCFG  | no legal configuration loaded; stream bits ignored
//   ACTIVE | shadow pattern valid; history shifts on each in_valid bit
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    seq_detector_param_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic {UNCFG = 1'b0, ACTIVE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               det_q, det_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               cfg_legal;
    logic               match;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            det_q   <= det_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        det_d   = 1'b0;

        // Shift form that also works for MAX_LEN == 1.
        hist_shift = (hist_q << 1) | MAX_LEN'(bus.sequence_in);
        fill_inc   = (fill_q == len_q) ? fill_q : fill_q + 1'b1;

        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end

        // Compare against the post-shift history so the pulse lands one
        // cycle after the completing bit.
        match = (((hist_shift ^ pat_q) & mask) == '0) && (fill_inc == len_q);

        cfg_legal = (bus.pattern_len != '0) &&
                    (bus.pattern_len <= LEN_W'(MAX_LEN));

        if (bus.cfg_load) begin
            cnt_d  = '0;
            hist_d = '0;
            fill_d = '0;
            if (cfg_legal) begin
                state_d = ACTIVE;
                pat_d   = bus.pattern;
                len_d   = bus.pattern_len;
                ovl_d   = bus.overlap;
                err_d   = 1'b0;
            end else begin
                state_d = UNCFG;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (bus.in_valid) begin
                        hist_d = hist_shift;
                        fill_d = fill_inc;
                        if (match) begin
                            det_d = 1'b1;
                            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                            if (!ovl_q) begin
                                fill_d = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.detector_out = det_q;
    assign bus.match_count  = cnt_q;
    assign bus.cfg_err      = err_q;
    assign bus.active       = (state_q == ACTIVE);

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
//   Drives two detector instances (CNT_W=8 and CNT_W=2) with the same
//   stimulus and compares both against a queue-based reference model.
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;

    logic clock;
    logic reset_n;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus8 ();
    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus2 ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the accepted bits since the last restart, newest last.
    bit         m_active;
    bit         m_err;
    bit         m_det;
    int         m_cnt8;
    int         m_cnt2;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_bits[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit tail_matches();
        int n;
        n = m_bits.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_err = 0; m_det = 0; m_cnt8 = 0; m_cnt2 = 0;
        m_pat = '0; m_len = 0; m_ovl = 0;
        m_bits.delete();
    endtask

    task automatic model_edge(input bit cl, input bit v, input bit d,
                              input logic [7:0] pat, input int len, input bit ovl);
        m_det = 0;
        if (cl) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
            m_bits.delete();
            if (len >= 1 && len <= MAX_LEN) begin
                m_active = 1; m_err = 0;
                m_pat = pat; m_len = len; m_ovl = ovl;
            end else begin
                m_active = 0; m_err = 1;
            end
        end else if (m_active && v) begin
            m_bits.push_back(d);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            if (tail_matches()) begin
                m_det = 1;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) m_bits.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("det8",    bus8.detector_out, m_det);
        chk("det2",    bus2.detector_out, m_det);
        chk("cnt8",    bus8.match_count,  m_cnt8);
        chk("cnt2",    bus2.match_count,  m_cnt2);
        chk("err8",    bus8.cfg_err,      m_err);
        chk("err2",    bus2.cfg_err,      m_err);
        chk("active8", bus8.active,       m_active);
        chk("active2", bus2.active,       m_active);
    endtask

    task automatic drive(input bit cl, input bit v, input bit d,
                         input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        bus8.cfg_load = cl; bus8.in_valid = v; bus8.sequence_in = d;
        bus8.pattern = pat; bus8.pattern_len = len; bus8.overlap = ovl;
        bus2.cfg_load = cl; bus2.in_valid = v; bus2.sequence_in = d;
        bus2.pattern = pat; bus2.pattern_len = len; bus2.overlap = ovl;
    endtask

    // One clock: apply inputs, take the edge, update the model, check #1 later.
    task automatic cycle(input bit cl, input bit v, input bit d,
                         input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        drive(cl, v, d, pat, len, ovl);
        @(posedge clock);
        model_edge(cl, v, d, pat, int'(len), ovl);
        #1;
        check_all();
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        cycle(1'b1, 1'b0, 1'b0, pat, len, ovl);
    endtask

    // Pattern inputs carry junk outside cfg_load; they must have no effect.
    task automatic send(input bit v, input bit d);
        cycle(1'b0, v, d, 8'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_active", bus8.active, 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Overlapping 1011
        cfg(8'b1011, 4'd4, 1'b1);
        send_bits(16'b1011011, 7);
        chk("tp_ovl_cnt", bus8.match_count, 2);

        // Non-overlapping 1011
        cfg(8'b1011, 4'd4, 1'b0);
        send_bits(16'b1011011, 7);
        chk("tp_novl_cnt", bus8.match_count, 1);

        // len=1, pattern 1, overlap
        cfg(8'b1, 4'd1, 1'b1);
        send_bits(16'b11101, 5);
        chk("tp_len1_cnt", bus8.match_count, 4);

        // Stall in the middle of 1011
        cfg(8'b1011, 4'd4, 1'b0);
        send(1'b1, 1'b1); send(1'b1, 1'b0);
        send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b0);
        send(1'b1, 1'b1); send(1'b1, 1'b1);
        chk("tp_stall_det", bus8.detector_out, 1);

        // Reset after 1,0,1
        cfg(8'b1011, 4'd4, 1'b0);
        send_bits(16'b101, 3);
        do_reset();
        send_bits(16'b1111, 4);

        // Illegal lengths
        cfg(8'hFF, 4'd0, 1'b1);
        chk("tp_len0_err", bus8.cfg_err, 1);
        send_bits(16'hFFFF, 6);
        chk("tp_len0_cnt", bus8.match_count, 0);
        cfg(8'hFF, 4'd9, 1'b1);
        send_bits(16'hFFFF, 4);

        // Saturation: CNT_W=2 at 3, CNT_W=8 at 255
        cfg(8'b1, 4'd1, 1'b1);
        send_bits(16'h1F, 5);
        chk("tp_sat2", bus2.match_count, 3);
        for (int i = 0; i < 260; i++) send(1'b1, 1'b1);
        chk("tp_sat8", bus8.match_count, 255);

        // Reconfiguration mid-stream; bit sent in the cfg_load cycle ignored
        cfg(8'b1011, 4'd4, 1'b1);
        send_bits(16'b101, 3);
        cycle(1'b1, 1'b1, 1'b1, 8'b110, 4'd3, 1'b0);
        chk("tp_reconf_clr", bus8.match_count, 0);
        send_bits(16'b110, 3);
        chk("tp_reconf_cnt", bus8.match_count, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 25) begin
                cfg(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom));
            end else if (r < 27) begin
                do_reset();
            end else begin
                send($urandom_range(0, 3) != 0, 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
